// File: rtl/fx_mode_scheduler.sv
// Runtime effect configuration: switch sync/debounce, auto pattern cycling,
// and frame-aligned application of pattern_sel / fx_enable.
module fx_mode_scheduler #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned AUTO_FRAMES     = 120,
    parameter bit          VS_POL          = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  sw_in,
    input  logic        vsync,
    output logic [2:0]  pattern_sel,
    output logic        fx_enable,
    output logic        mode_changed,
    output logic [15:0] frame_count,
    output logic [7:0]  leds
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int AW = $clog2(AUTO_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        APPLY
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          sw_s1_q, sw_s2_q;
    logic                vs_s1_q, vs_s2_q, vs_prev_q;
    logic [3:0]          db_q, db_d;
    logic [3:0][DW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]          auto_pat_q, auto_pat_d;
    logic [AW-1:0]       auto_cnt_q, auto_cnt_d;
    logic [2:0]          pat_q, pat_d;
    logic                fx_q, fx_d;
    logic                mc_q, mc_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;

    logic                frame_tick;
    logic                auto_active;
    logic [2:0]          tgt_pat;
    logic                tgt_fx;
    logic                mismatch;

    assign frame_tick  = (vs_s2_q == VS_POL) && (vs_prev_q != VS_POL);
    assign auto_active = &db_q[2:0];
    assign tgt_pat     = auto_active ? auto_pat_q : db_q[2:0];
    assign tgt_fx      = db_q[3];
    assign mismatch    = {tgt_pat, tgt_fx} != {pat_q, fx_q};

    always_comb begin
        db_d      = db_q;
        deb_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sw_s2_q[i] != db_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sw_s2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Outside auto mode, track the visible pattern so auto resumes from it
    always_comb begin
        auto_pat_d = auto_pat_q;
        auto_cnt_d = auto_cnt_q;
        if (!auto_active) begin
            auto_pat_d = pat_q;
            auto_cnt_d = '0;
        end else if (frame_tick) begin
            if (auto_cnt_q == AW'(AUTO_FRAMES - 1)) begin
                auto_cnt_d = '0;
                auto_pat_d = (auto_pat_q == 3'd6) ? 3'd0 : auto_pat_q + 3'd1;
            end else begin
                auto_cnt_d = auto_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        fx_d        = fx_q;
        mc_d        = 1'b0;
        frame_cnt_d = frame_cnt_q + {15'd0, frame_tick};
        unique case (state_q)
            IDLE: begin
                if (mismatch) state_d = PENDING;
            end
            PENDING: begin
                if (!mismatch)      state_d = IDLE;
                else if (frame_tick) state_d = APPLY;
            end
            APPLY: begin
                pat_d   = tgt_pat;
                fx_d    = tgt_fx;
                mc_d    = mismatch;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            vs_s1_q     <= 1'b0;
            vs_s2_q     <= 1'b0;
            vs_prev_q   <= 1'b0;
            db_q        <= '0;
            deb_cnt_q   <= '0;
            auto_pat_q  <= '0;
            auto_cnt_q  <= '0;
            pat_q       <= '0;
            fx_q        <= 1'b0;
            mc_q        <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sw_s1_q     <= sw_in;
            sw_s2_q     <= sw_s1_q;
            vs_s1_q     <= vsync;
            vs_s2_q     <= vs_s1_q;
            vs_prev_q   <= vs_s2_q;
            db_q        <= db_d;
            deb_cnt_q   <= deb_cnt_d;
            auto_pat_q  <= auto_pat_d;
            auto_cnt_q  <= auto_cnt_d;
            pat_q       <= pat_d;
            fx_q        <= fx_d;
            mc_q        <= mc_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pattern_sel  = pat_q;
    assign fx_enable    = fx_q;
    assign mode_changed = mc_q;
    assign frame_count  = frame_cnt_q;
    assign leds         = {fx_q, state_q == PENDING, auto_active, 2'b00, pat_q};

endmodule

// File: tb/tb_fx_mode_scheduler.sv
// Randomized + directed bench for fx_mode_scheduler against an
// event-level reference model evaluated every clock.
module tb_fx_mode_scheduler;

    localparam int DEB  = 4;
    localparam int AF   = 3;
    localparam int VPER = 100;
    localparam int VHI  = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw_in;
    logic        vsync = 1'b0;
    logic [2:0]  pattern_sel;
    logic        fx_enable;
    logic        mode_changed;
    logic [15:0] frame_count;
    logic [7:0]  leds;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;
    bit wrap_req = 1'b0;

    fx_mode_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .AUTO_FRAMES    (AF),
        .VS_POL         (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_in       (sw_in),
        .vsync       (vsync),
        .pattern_sel (pattern_sel),
        .fx_enable   (fx_enable),
        .mode_changed(mode_changed),
        .frame_count (frame_count),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        vsync = (vcnt < VHI);
        vcnt  = (vcnt + 1) % VPER;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw-input histories, a sliding debounce window,
    // and "armed" tracking of how long the target has disagreed.
    bit [3:0]  swh [0:2];
    bit        vh  [0:2];
    bit [3:0]  win [$];
    bit [3:0]  m_db;
    bit [2:0]  m_pat, m_ap;
    bit        m_fx, m_mc, m_pending;
    bit [15:0] m_fc;
    int        m_arun;
    bit        m_mm_prev, m_apply_prev, m_apply_next;

    always @(posedge clk) begin
        bit [3:0] synced, new_db;
        bit       tick, auto_on, mm, apply_k, armed, nxt, all_diff;
        bit [3:0] tgt;
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                swh[k] = '0;
                vh[k]  = 1'b0;
            end
            win.delete();
            m_db = '0; m_pat = '0; m_ap = '0; m_fx = 0; m_mc = 0;
            m_pending = 0; m_fc = '0; m_arun = 0;
            m_mm_prev = 0; m_apply_prev = 0; m_apply_next = 0;
        end else begin
            synced = swh[1];
            tick   = vh[1] && !vh[2];
            win.push_back(synced);
            if (win.size() > DEB) void'(win.pop_front());
            new_db = m_db;
            if (win.size() == DEB) begin
                for (int b = 0; b < 4; b++) begin
                    all_diff = 1'b1;
                    foreach (win[j]) if (win[j][b] == m_db[b]) all_diff = 1'b0;
                    if (all_diff) new_db[b] = ~m_db[b];
                end
            end
            auto_on = (m_db[2:0] == 3'd7);
            tgt     = {auto_on ? m_ap : m_db[2:0], m_db[3]};
            mm      = tgt != {m_pat, m_fx};
            apply_k = m_apply_next;
            armed   = m_mm_prev && !m_apply_prev && !apply_k;
            nxt     = armed && mm && tick;
            if (!auto_on) begin
                m_ap   = m_pat;
                m_arun = 0;
            end else if (tick) begin
                m_arun++;
                if (m_arun == AF) begin
                    m_arun = 0;
                    m_ap   = (m_ap + 3'd1) % 7;
                end
            end
            m_mc = apply_k && mm;
            if (apply_k) {m_pat, m_fx} = tgt;
            if (wrap_req) m_fc = 16'hFFFF;
            if (tick) m_fc = m_fc + 16'd1;
            m_pending    = mm && !apply_k && !nxt;
            m_mm_prev    = mm;
            m_apply_prev = apply_k;
            m_apply_next = nxt;
            m_db         = new_db;
            swh[2] = swh[1]; swh[1] = swh[0]; swh[0] = sw_in;
            vh[2]  = vh[1];  vh[1]  = vh[0];  vh[0]  = vsync;
        end
        #1;
        chk("pattern_sel",  32'(pattern_sel),  32'(m_pat));
        chk("fx_enable",    32'(fx_enable),    32'(m_fx));
        chk("mode_changed", 32'(mode_changed), 32'(m_mc));
        chk("frame_count",  32'(frame_count),  32'(m_fc));
        chk("leds", 32'(leds),
            32'({m_fx, m_pending, m_db[2:0] == 3'd7, 2'b00, m_pat}));
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (vcnt != ph && guard < 2 * VPER) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        reset = 1'b1;
        sw_in = 4'h0;
        cycles(3);
        reset = 1'b0;
        cycles(20);

        sw_in = 4'b0010;
        cycles(3);
        sw_in = 4'b0000;
        cycles(3 * VPER);
        chk("glitch_pat", 32'(pattern_sel), 32'd0);
        sw_in = 4'b0010;
        cycles(2 * VPER + 20);
        chk("debounce_pat", 32'(pattern_sel), 32'd2);

        wait_phase(50);
        sw_in = 4'b1101;
        cycles(2 * VPER + 20);
        chk("align_pat", 32'(pattern_sel), 32'd5);
        chk("align_fx", 32'(fx_enable), 32'd1);

        wait_phase(20);
        sw_in = 4'b1011;
        wait_phase(60);
        sw_in = 4'b1101;
        cycles(2 * VPER);
        chk("revert_pat", 32'(pattern_sel), 32'd5);

        sw_in = 4'b1111;
        cycles(15 * VPER);

        wait_phase(20);
        sw_in = 4'b0000;
        wait_phase(50);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        chk("reset_pat", 32'(pattern_sel), 32'd0);
        chk("reset_fcnt", 32'(frame_count), 32'd0);
        cycles(3 * VPER);

        wait_phase(50);
        force dut.frame_cnt_q = 16'hFFFF;
        wrap_req = 1'b1;
        #1 release dut.frame_cnt_q;
        @(negedge clk);
        wrap_req = 1'b0;
        cycles(VPER);
        chk("wrap_fcnt", 32'(frame_count), 32'd0);

        for (int s = 0; s < 60; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 3) sw_in = {sw_in[3] ^ 1'($urandom_range(0, 1)), 3'd7};
            else       sw_in = 4'($urandom_range(0, 15));
            if (r == 9) cycles(int'($urandom_range(1, 5)));
            else        cycles(int'($urandom_range(10, 300)));
            if (s % 20 == 19) begin
                reset = 1'b1;
                cycles(1);
                reset = 1'b0;
            end
        end
        cycles(4 * VPER);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
